// File: rtl/fifo_wr_framer.sv
// Write-side framer ahead of the async FIFO: wraps each source frame as
// SOF, sequence number, payload words, two's-complement checksum.
module fifo_wr_framer #(
   parameter int               WIDTH   = 8,
   parameter int               MAX_LEN = 16,
   parameter logic [WIDTH-1:0] SOF     = 8'hA5
) (
   input  logic             wr_clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [WIDTH-1:0] fifo_data,
   output logic             fifo_wr,
   input  logic             wr_full,
   output logic [7:0]       frame_count,
   output logic             trunc_err
);

   localparam int LEN_W = $clog2(MAX_LEN + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_SEQ,
      S_PAYLOAD,
      S_CSUM
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_seq;
   logic [WIDTH-1:0] r_sum;
   logic [LEN_W-1:0] r_len;
   logic [7:0]       r_frame_cnt;
   logic             r_trunc;
   logic             w_accept;
   logic             w_len_max;

   // Checksum word makes payload plus checksum sum to zero mod 2^WIDTH.
   function automatic logic [WIDTH-1:0] f_csum(input logic [WIDTH-1:0] sum);
      return ~sum + WIDTH'(1);
   endfunction

   assign w_len_max   = (r_len == LEN_W'(MAX_LEN - 1));
   assign frame_count = r_frame_cnt;
   assign trunc_err   = r_trunc;

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      fifo_wr     = 1'b0;
      fifo_data   = '0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid) w_state_nxt = S_HDR;
         end
         S_HDR: begin
            fifo_data = SOF;
            fifo_wr   = !wr_full;
            if (!wr_full) w_state_nxt = S_SEQ;
         end
         S_SEQ: begin
            fifo_data = r_seq;
            fifo_wr   = !wr_full;
            if (!wr_full) w_state_nxt = S_PAYLOAD;
         end
         S_PAYLOAD: begin
            fifo_data = in_data;
            in_ready  = !wr_full;
            w_accept  = in_valid && !wr_full;
            fifo_wr   = w_accept;
            if (w_accept && (in_last || w_len_max)) w_state_nxt = S_CSUM;
         end
         S_CSUM: begin
            fifo_data = f_csum(r_sum);
            fifo_wr   = !wr_full;
            if (!wr_full) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Reset release is assumed already synchronised to wr_clk, shared with the FIFO.
   always_ff @(posedge wr_clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_seq       <= '0;
         r_sum       <= '0;
         r_len       <= '0;
         r_frame_cnt <= '0;
         r_trunc     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_SEQ: begin
               if (!wr_full) begin
                  r_sum <= '0;
                  r_len <= '0;
               end
            end
            S_PAYLOAD: begin
               if (w_accept) begin
                  r_sum <= r_sum + in_data;
                  r_len <= r_len + LEN_W'(1);
                  if (w_len_max && !in_last) r_trunc <= 1'b1;
               end
            end
            S_CSUM: begin
               if (!wr_full) begin
                  r_seq       <= r_seq + WIDTH'(1);
                  r_frame_cnt <= r_frame_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_framer.sv
// Scoreboard bench for fifo_wr_framer: expected FIFO words are queued as
// frames are driven and compared as the block writes them.
module tb_fifo_wr_framer;

   localparam int         TB_MAXL = 16;
   localparam logic [7:0] TB_SOF  = 8'hA5;

   logic       wr_clk;
   logic       reset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic [7:0] fifo_data;
   logic       fifo_wr;
   logic       wr_full;
   logic [7:0] frame_count;
   logic       trunc_err;

   fifo_wr_framer #(
      .WIDTH   (8),
      .MAX_LEN (TB_MAXL),
      .SOF     (8'hA5)
   ) dut (
      .wr_clk      (wr_clk),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .fifo_data   (fifo_data),
      .fifo_wr     (fifo_wr),
      .wr_full     (wr_full),
      .frame_count (frame_count),
      .trunc_err   (trunc_err)
   );

   initial wr_clk = 1'b0;
   always #5 wr_clk = ~wr_clk;

   int         n_pass = 0;
   int         n_chk  = 0;
   int         cyc    = 0;
   int         first_lat;
   logic [7:0] exp_q[$];
   logic [7:0] pay[$];
   logic [7:0] wr_dat[$];
   int         wr_cyc[$];
   logic [7:0] exp_seq = 8'd0;
   logic [7:0] exp_fc  = 8'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else n_pass++;
   endtask

   always @(posedge wr_clk) cyc <= cyc + 1;

   always @(negedge wr_clk) begin
      if (!reset) begin
         chk("wr_while_full", 32'(fifo_wr & wr_full), 32'd0);
         chk("rdy_while_full", 32'(in_ready & wr_full), 32'd0);
         if (fifo_wr) begin
            wr_dat.push_back(fifo_data);
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("extra_write", 32'(fifo_data), 32'hFFFF_FFFF);
            else chk("fifo_word", 32'(fifo_data), 32'(exp_q.pop_front()));
         end
      end
   end

   // Reference framing: split the source frame into MAX_LEN chunks.
   function automatic void push_stream();
      int i = 0;
      while (i < pay.size()) begin
         logic [7:0] s;
         s = 8'd0;
         exp_q.push_back(TB_SOF);
         exp_q.push_back(exp_seq);
         for (int k = 0; k < TB_MAXL && i < pay.size(); k++) begin
            exp_q.push_back(pay[i]);
            s = s + pay[i];
            i++;
         end
         exp_q.push_back(8'(8'd0 - s));
         exp_seq = exp_seq + 8'd1;
         exp_fc  = exp_fc + 8'd1;
      end
   endfunction

   task automatic send_word(input logic [7:0] d, input bit last, output int waited);
      bit acc;
      acc      = 1'b0;
      waited   = 0;
      in_data  = d;
      in_last  = last;
      in_valid = 1'b1;
      while (!acc && waited < 64) begin
         @(negedge wr_clk);
         waited++;
         acc = in_ready;
         @(posedge wr_clk);
         #1;
      end
      chk("accept", 32'(acc), 32'd1);
   endtask

   task automatic stall(input int n);
      wr_full = 1'b1;
      repeat (n) begin
         @(negedge wr_clk);
         chk("stall_wr", 32'(fifo_wr), 32'd0);
         chk("stall_rdy", 32'(in_ready), 32'd0);
         @(posedge wr_clk);
         #1;
      end
      wr_full = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      in_valid = 1'b0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge wr_clk);
         #1;
         n++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      if (exp_q.size() != 0) exp_q.delete();
   endtask

   task automatic send_frame(input bit do_drain);
      int lat;
      push_stream();
      foreach (pay[i]) begin
         send_word(pay[i], (i == pay.size() - 1), lat);
         if (i == 0) first_lat = lat;
      end
      if (do_drain) wait_drain(200);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int         lat;
      logic [7:0] s0;
      reset    = 1'b1;
      wr_full  = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h55;
      in_last  = 1'b0;
      repeat (3) @(posedge wr_clk);
      #1;
      chk("rst_fifo_wr", 32'(fifo_wr), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_fifo_data", 32'(fifo_data), 32'd0);
      chk("rst_frame_count", 32'(frame_count), 32'd0);
      chk("rst_trunc_err", 32'(trunc_err), 32'd0);
      in_valid = 1'b0;
      reset    = 1'b0;
      @(posedge wr_clk);
      #1;

      // basic frame
      wr_dat.delete();
      pay = '{8'h01, 8'h02, 8'h03};
      send_frame(1);
      chk("rdy_latency", 32'(first_lat - 1), 32'd3);
      chk("basic_csum", 32'(wr_dat[5]), 32'hFA);
      chk("basic_fc", 32'(frame_count), 32'(exp_fc));
      chk("basic_trunc", 32'(trunc_err), 32'd0);

      // back-pressure in payload and checksum
      pay = '{8'h01, 8'h02, 8'h03};
      push_stream();
      send_word(8'h01, 1'b0, lat);
      in_data = 8'h02;
      stall(4);
      send_word(8'h02, 1'b0, lat);
      send_word(8'h03, 1'b1, lat);
      in_valid = 1'b0;
      stall(4);
      wait_drain(50);
      chk("bp_fc", 32'(frame_count), 32'(exp_fc));

      // truncation at MAX_LEN
      wr_dat.delete();
      s0 = exp_seq;
      pay.delete();
      for (int i = 0; i < 20; i++) pay.push_back(8'(i));
      send_frame(1);
      chk("trunc_csum", 32'(wr_dat[18]), 32'h88);
      chk("trunc_seq2", 32'(wr_dat[20]), 32'(8'(s0 + 8'd1)));
      chk("trunc_err", 32'(trunc_err), 32'd1);
      chk("trunc_fc", 32'(frame_count), 32'(exp_fc));

      // back-to-back frames with continuous valid
      wr_cyc.delete();
      pay = '{8'h11, 8'h22};
      send_frame(0);
      pay = '{8'h33, 8'h44};
      send_frame(1);
      chk("b2b_gap", 32'(wr_cyc[5] - wr_cyc[4]), 32'd2);
      chk("b2b_fc", 32'(frame_count), 32'(exp_fc));

      // reset in the middle of a payload
      pay = '{8'h31, 8'h32, 8'h33, 8'h34};
      push_stream();
      send_word(8'h31, 1'b0, lat);
      send_word(8'h32, 1'b0, lat);
      reset = 1'b1;
      #1;
      chk("midrst_fifo_wr", 32'(fifo_wr), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      chk("midrst_fifo_data", 32'(fifo_data), 32'd0);
      chk("midrst_fc", 32'(frame_count), 32'd0);
      chk("midrst_trunc", 32'(trunc_err), 32'd0);
      exp_q.delete();
      exp_seq  = 8'd0;
      exp_fc   = 8'd0;
      in_valid = 1'b0;
      @(posedge wr_clk);
      #1;
      reset = 1'b0;
      @(posedge wr_clk);
      #1;

      // sequence wrap over 256 one-word frames
      for (int f = 0; f < 256; f++) begin
         if (f == 0) wr_dat.delete();
         pay = '{8'($urandom_range(0, 255))};
         send_frame(1);
         if (f == 0) begin
            chk("post_rst_sof", 32'(wr_dat[0]), 32'hA5);
            chk("post_rst_seq", 32'(wr_dat[1]), 32'h00);
         end
      end
      chk("wrap_fc", 32'(frame_count), 32'(exp_fc));
      wr_dat.delete();
      pay = '{8'h7F};
      send_frame(1);
      chk("wrap_seq", 32'(wr_dat[1]), 32'h00);
      chk("wrap_fc2", 32'(frame_count), 32'(exp_fc));

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
